// File: rtl/mult32x32_ctrl.sv
// Sequencing controller for the 32x32 multiplier: clear, four 16x16 accumulates, done.
// Optional `MULT_SKIP_ZERO_EN` skips accumulates of zero partial products and short-cuts zero operands.
module mult32x32_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        a_sel,
  output logic        b_sel,
  output logic [1:0]  shift_sel,
  output logic        upd_prod,
  output logic        clr_prod
);

  // state | meaning
  // IDLE  | waiting for start
  // CLR   | clear product register
  // P00   | accumulate a_lo*b_lo
  // P01   | accumulate a_lo*b_hi << 16
  // P10   | accumulate a_hi*b_lo << 16
  // P11   | accumulate a_hi*b_hi << 32
  // DONE  | product final, one-cycle done pulse
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_P00  = 3'd2;
  localparam logic [2:0] S_P01  = 3'd3;
  localparam logic [2:0] S_P10  = 3'd4;
  localparam logic [2:0] S_P11  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       upd_base;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_CLR;
`ifdef MULT_SKIP_ZERO_EN
      S_CLR:  state_nxt = ((a == 32'd0) || (b == 32'd0)) ? S_DONE : S_P00;
`else
      S_CLR:  state_nxt = S_P00;
`endif
      S_P00:  state_nxt = S_P01;
      S_P01:  state_nxt = S_P10;
      S_P10:  state_nxt = S_P11;
      S_P11:  state_nxt = S_DONE;
      S_DONE: state_nxt = start ? S_CLR : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    shift_sel = 2'b11;
    upd_base  = 1'b0;
    clr_prod  = 1'b0;
    case (state)
      S_CLR: begin
        busy     = 1'b1;
        clr_prod = 1'b1;
      end
      S_P00: begin
        busy      = 1'b1;
        a_sel     = 1'b1;
        b_sel     = 1'b1;
        shift_sel = 2'b00;
        upd_base  = 1'b1;
      end
      S_P01: begin
        busy      = 1'b1;
        a_sel     = 1'b1;
        shift_sel = 2'b01;
        upd_base  = 1'b1;
      end
      S_P10: begin
        busy      = 1'b1;
        b_sel     = 1'b1;
        shift_sel = 2'b01;
        upd_base  = 1'b1;
      end
      S_P11: begin
        busy      = 1'b1;
        shift_sel = 2'b10;
        upd_base  = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

`ifdef MULT_SKIP_ZERO_EN
  logic [15:0] a_half;
  logic [15:0] b_half;

  // A zero half means a zero partial product, so the accumulate is skipped.
  assign a_half   = a_sel ? a[15:0] : a[31:16];
  assign b_half   = b_sel ? b[15:0] : b[31:16];
  assign upd_prod = upd_base & (|a_half) & (|b_half);
`else
  logic unused_operands;

  assign unused_operands = ^{a, b};
  assign upd_prod        = upd_base;
`endif

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// Directed bench for mult32x32_ctrl with a behavioural datapath model for the product register.
module tb_mult32x32_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        a_sel;
  logic        b_sel;
  logic [1:0]  shift_sel;
  logic        upd_prod;
  logic        clr_prod;

  logic [63:0] product;
  logic [15:0] a_half;
  logic [15:0] b_half;
  logic [63:0] partial;
  logic [63:0] addend;
  logic [7:0]  ctl;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] V_IDLE = 8'h0C;
  localparam logic [7:0] V_CLR  = 8'h8D;
  localparam logic [7:0] V_P00  = 8'hB2;
  localparam logic [7:0] V_P01  = 8'hA6;
  localparam logic [7:0] V_P10  = 8'h96;
  localparam logic [7:0] V_P11  = 8'h8A;
  localparam logic [7:0] V_DONE = 8'h4C;

  mult32x32_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .shift_sel (shift_sel),
    .upd_prod  (upd_prod),
    .clr_prod  (clr_prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctl     = {busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod};
  assign a_half  = a_sel ? a[15:0] : a[31:16];
  assign b_half  = b_sel ? b[15:0] : b[31:16];
  assign partial = {32'd0, 32'(a_half) * 32'(b_half)};

  always_comb begin
    addend = 64'd0;
    case (shift_sel)
      2'b00: addend = partial;
      2'b01: addend = partial << 16;
      2'b10: addend = partial << 32;
      default: addend = 64'd0;
    endcase
  end

  always @(posedge clk or negedge reset) begin
    if (!reset)        product <= 64'd0;
    else if (clr_prod) product <= 64'd0;
    else if (upd_prod) product <= product + addend;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launches one operation and reports cycles to done, final product and upd_prod over P00..P11.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input int exp_lat, input logic [63:0] exp_prod, input logic [3:0] exp_pat);
    int lat;
    logic [3:0] pat;
    lat = 0;
    pat = 4'd0;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy && !clr_prod) pat = {pat[2:0], upd_prod};
    end while (!done && lat < 20);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_product"}, product, exp_prod);
    chk({tag, "_upd_pattern"}, 64'(pat), 64'(exp_pat));
  endtask

  initial begin
    int dones;
    int first_done;
    reset = 1'b0;
    start = 1'b0;
    a = 32'd0;
    b = 32'd0;

    // Reset state
    @(negedge clk);
    chk("reset_outputs", 64'(ctl), 64'(V_IDLE));
    start = 1'b1;
    @(negedge clk);
    chk("reset_ignores_start", 64'(ctl), 64'(V_IDLE));
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("idle_no_start", 64'(ctl), 64'(V_IDLE));

    // Max operands with a full per-cycle output trace
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("trace_c1_clr", 64'(ctl), 64'(V_CLR));
    @(negedge clk);
    chk("trace_c2_p00", 64'(ctl), 64'(V_P00));
    @(negedge clk);
    chk("trace_c3_p01", 64'(ctl), 64'(V_P01));
    @(negedge clk);
    chk("trace_c4_p10", 64'(ctl), 64'(V_P10));
    @(negedge clk);
    chk("trace_c5_p11", 64'(ctl), 64'(V_P11));
    @(negedge clk);
    chk("trace_c6_done", 64'(ctl), 64'(V_DONE));
    chk("max_product", product, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    chk("after_done_idle", 64'(ctl), 64'(V_IDLE));
    chk("product_held", product, 64'hFFFF_FFFE_0000_0001);

    run_op("mixed", 32'h0001_0002, 32'h0003_0004, 6, 64'h0000_0003_000A_0008, 4'b1111);

    // Back-to-back: start held through DONE
    @(negedge clk);
    a = 32'd5;
    b = 32'd9;
    start = 1'b1;
    first_done = 0;
    for (int i = 1; i <= 20 && first_done == 0; i++) begin
      @(negedge clk);
      if (done) first_done = i;
    end
    chk("b2b_first_latency", 64'(first_done), 64'd6);
    chk("b2b_first_product", product, 64'd45);
    a = 32'd7;
    b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_clr_after_done", 64'(ctl), 64'(V_CLR));
    first_done = 0;
    for (int i = 2; i <= 20 && first_done == 0; i++) begin
      @(negedge clk);
      if (done) first_done = i;
    end
    chk("b2b_second_latency", 64'(first_done), 64'd6);
    chk("b2b_second_product", product, 64'd42);

    // Start pulse during P10 must not restart
    @(negedge clk);
    a = 32'd3;
    b = 32'd4;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_start_p11", 64'(ctl), 64'(V_P11));
    dones = 0;
    first_done = 0;
    for (int i = 6; i <= 16; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (first_done == 0) first_done = i;
      end
    end
    chk("busy_start_done_count", 64'(dones), 64'd1);
    chk("busy_start_latency", 64'(first_done), 64'd6);
    chk("busy_start_product", product, 64'd12);

    // Reset asserted during P01
    @(negedge clk);
    a = 32'd11;
    b = 32'd13;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_in_p01", 64'(ctl), 64'(V_P01));
    reset = 1'b0;
    #1;
    chk("rst_mid_immediate", 64'(ctl), 64'(V_IDLE));
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rst_mid_no_done", 64'(dones), 64'd0);
    chk("rst_mid_idle", 64'(ctl), 64'(V_IDLE));
    run_op("after_rst", 32'h0000_0010, 32'h0000_0010, 6, 64'h100, 4'b1111);

`ifdef MULT_SKIP_ZERO_EN
    run_op("zero_b", 32'h1234_5678, 32'd0, 2, 64'd0, 4'b0000);
    run_op("skip_halves", 32'h0000_0005, 32'h0003_0000, 6, 64'h0000_0000_000F_0000, 4'b0100);
`else
    run_op("zero_b", 32'h1234_5678, 32'd0, 6, 64'd0, 4'b1111);
    run_op("skip_halves", 32'h0000_0005, 32'h0003_0000, 6, 64'h0000_0000_000F_0000, 4'b1111);
`endif

    @(negedge clk);
    chk("final_idle", 64'(ctl), 64'(V_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
